// File: rtl/pipelined_barrel_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipelined_barrel_shifter
// Purpose  : Valid/ready pipelined barrel shifter (LSL/LSR/ASR/ROL/ROR) with
//            carry-out, illegal-op flag and a sideband tag.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 1,
    parameter int TAGW      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [$clog2(WIDTH)-1:0]  in_shamt,
    input  logic [2:0]                in_op,
    input  logic [TAGW-1:0]           in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_carry,
    output logic                      out_err,
    output logic [TAGW-1:0]           out_tag
);

    localparam int SHW = $clog2(WIDTH);
    localparam int LAT = (SHW + REG_EVERY - 1) / REG_EVERY;

    localparam logic [2:0] c_OP_LSL = 3'd0;
    localparam logic [2:0] c_OP_LSR = 3'd1;
    localparam logic [2:0] c_OP_ASR = 3'd2;
    localparam logic [2:0] c_OP_ROL = 3'd3;
    localparam logic [2:0] c_OP_ROR = 3'd4;

    logic w_adv;
    logic w_in_err;

    assign w_in_err = (in_op > c_OP_ROR);
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // One power-of-two step; the carry of the last active step is the last
    // bit shifted out of the whole operation.
    function automatic logic [WIDTH:0] f_stage(
        input logic [WIDTH-1:0] d,
        input logic             c,
        input logic [2:0]       op,
        input logic             en,
        input int               n
    );
        logic [WIDTH-1:0] w_l;
        logic [WIDTH-1:0] w_r;
        logic [WIDTH-1:0] w_a;
        w_l     = d << (n - 1);
        w_r     = d >> (n - 1);
        w_a     = $signed(d) >>> n;
        f_stage = {c, d};
        if (en) begin
            case (op)
                c_OP_LSL: f_stage = {w_l[WIDTH-1], d << n};
                c_OP_LSR: f_stage = {w_r[0], d >> n};
                c_OP_ASR: f_stage = {w_r[0], w_a};
                c_OP_ROL: f_stage = {1'b0, (d << n) | (d >> (WIDTH - n))};
                c_OP_ROR: f_stage = {1'b0, (d >> n) | (d << (WIDTH - n))};
                default:  f_stage = {c, d};
            endcase
        end
    endfunction

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int G = k / REG_EVERY;
        logic [WIDTH-1:0] w_si;
        logic             w_ci;
        logic [2:0]       w_op;
        logic             w_bit;
        logic             w_err;
        logic [WIDTH:0]   w_res;
        logic [WIDTH-1:0] w_so;
        logic             w_co;

        if (G == 0) begin : g_meta_in
            assign w_op  = in_op;
            assign w_bit = in_shamt[k];
            assign w_err = w_in_err;
        end else begin : g_meta_reg
            assign w_op  = g_slot[G-1].g_meta.r_op;
            assign w_bit = g_slot[G-1].g_meta.r_shamt[k];
            assign w_err = g_slot[G-1].r_err;
        end

        if (k == 0) begin : g_src_in
            assign w_si = in_data;
            assign w_ci = 1'b0;
        end else if (k % REG_EVERY == 0) begin : g_src_reg
            assign w_si = g_slot[G-1].r_data;
            assign w_ci = g_slot[G-1].r_carry;
        end else begin : g_src_prev
            assign w_si = g_stage[k-1].w_so;
            assign w_ci = g_stage[k-1].w_co;
        end

        assign w_res = f_stage(w_si, w_ci, w_op, w_bit & ~w_err, 1 << k);
        assign w_so  = w_res[WIDTH-1:0];
        assign w_co  = w_res[WIDTH];
    end

    for (genvar j = 0; j < LAT; j++) begin : g_slot
        localparam int E = ((j + 1) * REG_EVERY < SHW) ? ((j + 1) * REG_EVERY - 1) : (SHW - 1);
        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             r_carry;
        logic             r_err;
        logic [TAGW-1:0]  r_tag;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_carry <= 1'b0;
            end else if (w_adv) begin
                r_data  <= g_stage[E].w_so;
                r_carry <= g_stage[E].w_co;
            end
        end

        if (j == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_tag   <= '0;
                end else if (w_adv) begin
                    r_valid <= in_valid;
                    r_err   <= w_in_err;
                    r_tag   <= in_tag;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_tag   <= '0;
                end else if (w_adv) begin
                    r_valid <= g_slot[j-1].r_valid;
                    r_err   <= g_slot[j-1].r_err;
                    r_tag   <= g_slot[j-1].r_tag;
                end
            end
        end

        // Only the shift-amount bits still to be consumed travel onward.
        if (j < LAT - 1) begin : g_meta
            logic [2:0]       r_op;
            logic [SHW-1:E+1] r_shamt;
            if (j == 0) begin : g_meta_in
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_op    <= '0;
                        r_shamt <= '0;
                    end else if (w_adv) begin
                        r_op    <= in_op;
                        r_shamt <= in_shamt[SHW-1:E+1];
                    end
                end
            end else begin : g_meta_prev
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_op    <= '0;
                        r_shamt <= '0;
                    end else if (w_adv) begin
                        r_op    <= g_slot[j-1].g_meta.r_op;
                        r_shamt <= g_slot[j-1].g_meta.r_shamt[SHW-1:E+1];
                    end
                end
            end
        end
    end

    assign out_valid = g_slot[LAT-1].r_valid;
    assign out_data  = g_slot[LAT-1].r_data;
    assign out_carry = g_slot[LAT-1].r_carry;
    assign out_err   = g_slot[LAT-1].r_err;
    assign out_tag   = g_slot[LAT-1].r_tag;

endmodule
`default_nettype wire
